// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and JAL decode helpers for the fetch unit
//
// Contents:
//   ADDR_W, INSTR_W   : word-address and instruction widths
//   OPC_JAL           : RISC-V JAL major opcode
//   fetch_state_t     : RUN / REDIR fetch states
//   fetch_entry_t     : buffered instruction word plus its fetch address
//   imm_j()           : J-type immediate (byte offset, 21 bits, bit 0 always 0)
//   jal_word_offset() : J-type immediate as a word offset, modulo the address space

package fetch_pkg;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [20:0] imm_j(input logic [INSTR_W-1:0] instr);
    return {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // Memory is word addressed, so the byte offset drops its two low bits and
  // wraps to the address width.
  function automatic logic [ADDR_W-1:0] jal_word_offset(input logic [INSTR_W-1:0] instr);
    return ADDR_W'(imm_j(instr) >> 2);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry in-order buffer between instruction memory and decode
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   push        : write push_data at the tail
//   push_data   : instruction word plus fetch address
//   pop         : release the head entry (ignored when empty)
//   data        : head entry, stable until popped
//   count       : number of valid entries (0..2)
//   valid       : count != 0

module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t data,
  output logic [1:0]   count,
  output logic         valid
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;

  assign valid  = (count != 2'd0);
  assign do_pop = pop && valid;
  assign data   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Space is reserved when the read is issued, so a push into a full buffer
  // means the issue throttle is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) push |-> (count != 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC steering, imem read issue, buffered stream to decode
//
// Build option: FETCH_JAL_REDIRECT_EN enables JAL redirect (state REDIR, squash of the
// wrong-path read); without it fetch is strictly sequential and pc_jump is 0.
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   pc_next_address  : current fetch address F from the PC register
//   pc_address       : base returned to the PC (next = base + jump, or base + 1 if jump == 0)
//   pc_jump          : offset returned to the PC
//   imem_en          : read strobe, imem_addr = F
//   imem_rdata       : read data, valid the cycle after imem_en
//   instr_valid/instr_ready/instr_data/instr_pc : in-order stream to decode

module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_next_address,
  output logic [ADDR_W-1:0]  pc_address,
  output logic [ADDR_W-1:0]  pc_jump,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
);

  logic              inflight;
  logic [ADDR_W-1:0] resp_pc;
  logic              issue;
  logic              capture;
  logic              deliver;
  logic [1:0]        buf_count;
  logic              buf_valid;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  // A read is only issued when the buffer already has room for its response,
  // counting the read still in flight.
  assign issue     = !reset && (({1'b0, buf_count} + {2'b00, inflight}) < 3'd2);
  assign imem_en   = issue;
  assign imem_addr = pc_next_address;

  assign push_entry  = '{instr: imem_rdata, pc: resp_pc};
  assign deliver     = buf_valid && instr_ready;
  assign instr_valid = buf_valid;
  assign instr_data  = head_entry.instr;
  assign instr_pc    = head_entry.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      resp_pc  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        resp_pc <= pc_next_address;
      end
    end
  end

`ifdef FETCH_JAL_REDIRECT_EN
  fetch_state_t      state;
  fetch_state_t      state_next;
  logic              squash;
  logic              squash_next;
  logic              discard;
  logic              redirect;
  logic [ADDR_W-1:0] jal_off;

  // The only read that can be on the wrong path is the one issued in the
  // redirect cycle itself; its response arrives during REDIR.
  assign discard  = inflight && (state == ST_REDIR) && squash;
  assign capture  = inflight && !discard;
  assign redirect = capture && (imem_rdata[6:0] == OPC_JAL);
  assign jal_off  = jal_word_offset(imem_rdata);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      squash <= 1'b0;
    end else begin
      state  <= state_next;
      squash <= squash_next;
    end
  end

  always_comb begin
    state_next  = state;
    squash_next = squash;
    case (state)
      ST_RUN: begin
        if (redirect) begin
          state_next  = ST_REDIR;
          squash_next = issue;
        end
      end
      ST_REDIR: begin
        if (redirect) begin
          state_next  = ST_REDIR;
          squash_next = issue;
        end else begin
          state_next  = ST_RUN;
          squash_next = 1'b0;
        end
      end
      default: begin
        state_next  = ST_RUN;
        squash_next = 1'b0;
      end
    endcase
  end
`else
  assign capture = inflight;
`endif

  // PC steering. The PC adds 1 when jump is 0, so "stay at X" is expressed as
  // base X-1, and a zero-offset JAL uses the same trick to land on itself.
  always_comb begin
    pc_address = pc_next_address - ADDR_W'(1);
    pc_jump    = '0;
    if (reset) begin
      pc_address = '1;
    end
`ifdef FETCH_JAL_REDIRECT_EN
    else if (redirect) begin
      if (jal_off != '0) begin
        pc_address = resp_pc;
        pc_jump    = jal_off;
      end else begin
        pc_address = resp_pc - ADDR_W'(1);
      end
    end
`endif
    else if (issue) begin
      pc_address = pc_next_address;
    end
  end

  fetch_buffer u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (push_entry),
    .pop       (deliver),
    .data      (head_entry),
    .count     (buf_count),
    .valid     (buf_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with PC, imem and program-order model

module tb_fetch_unit;

`ifdef FETCH_JAL_REDIRECT_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [5:0]  pc;
  logic [5:0]  pc_address;
  logic [5:0]  pc_jump;
  logic        imem_en;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [5:0]  instr_pc;

  logic [31:0] mem      [64];
  bit          is_jal   [64];
  int          jal_boff [64];

  logic [5:0]  exp_pc [$];
  int          total;
  int          bad;
  int          delivered;
  int          hold0;
  bit          pc_rule_on;
  bit          hold_prev;
  logic [31:0] prev_data;
  logic [5:0]  prev_pc;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc_next_address (pc),
    .pc_address      (pc_address),
    .pc_jump         (pc_jump),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: next = base + jump, or base + 1 when jump is 0.
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= 6'd0;
    else if (pc_jump == 6'd0) pc <= pc_address + 6'd1;
    else pc <= pc_address + pc_jump;
  end

  // Synchronous-read instruction memory.
  initial imem_rdata = 32'd0;
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] jal_word(input int boff);
    logic [20:0] imm;
    imm = 21'(boff);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  // Program-order successor: a JAL jumps by its byte offset / 4 words.
  function automatic logic [5:0] arch_next(input logic [5:0] p);
    if (JAL_EN && is_jal[p]) return 6'(int'(p) + jal_boff[p] / 4);
    return p + 6'd1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      mem[i]      = NOP;
      is_jal[i]   = 1'b0;
      jal_boff[i] = 0;
    end
  endtask

  task automatic set_jal(input int idx, input int boff);
    mem[idx]      = jal_word(boff);
    is_jal[idx]   = 1'b1;
    jal_boff[idx] = boff;
  endtask

  task automatic random_mem();
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(99) < 25) begin
        set_jal(i, (int'($urandom_range(63)) - 32) * 4);
      end else begin
        w = $urandom();
        w[6:0] = 7'b0010011;
        mem[i]      = w;
        is_jal[i]   = 1'b0;
        jal_boff[i] = 0;
      end
    end
  endtask

  // Scoreboard / monitor: every accepted beat must be the next program-order address.
  always @(negedge clk) begin
    logic [5:0] e;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (instr_valid && instr_ready) begin
        if (exp_pc.size() == 0) begin
          chk("stream_extra", 32'(instr_pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_pc.pop_front();
          chk("instr_pc", 32'(instr_pc), 32'(e));
          chk("instr_data", instr_data, mem[e]);
          delivered++;
        end
      end
      if (hold_prev) begin
        chk("stall_data_stable", instr_data, prev_data);
        chk("stall_pc_stable", 32'(instr_pc), 32'(prev_pc));
      end
      hold_prev = instr_valid && !instr_ready;
      prev_data = instr_data;
      prev_pc   = instr_pc;
      if (pc_rule_on) begin
        chk("imem_addr", 32'(imem_addr), 32'(pc));
        if (imem_en) begin
          chk("pc_advance", 32'({pc_jump, pc_address}), 32'({6'd0, pc}));
        end else begin
          chk("pc_hold", 32'({pc_jump, pc_address}), 32'({6'd0, 6'(pc - 6'd1)}));
          if (pc == 6'd0) hold0++;
        end
      end
    end
  end

  task automatic enter_reset();
    @(posedge clk);
    #1;
    reset       = 1'b1;
    instr_ready = 1'b0;
    pc_rule_on  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_pc_address", 32'(pc_address), 32'h3F);
    chk("rst_pc_jump", 32'(pc_jump), 32'd0);
  endtask

  task automatic start_stream(input bit rdy);
    logic [5:0] p;
    exp_pc.delete();
    p = 6'd0;
    for (int i = 0; i < 400; i++) begin
      exp_pc.push_back(p);
      p = arch_next(p);
    end
    delivered = 0;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    instr_ready = rdy;
    #1;
    chk("first_issue_en", 32'(imem_en), 32'd1);
    chk("first_issue_addr", 32'(imem_addr), 32'd0);
    @(posedge clk);
    #1;
    chk("startup_not_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("startup_valid", 32'(instr_valid), 32'd1);
    chk("startup_pc", 32'(instr_pc), 32'd0);
  endtask

  task automatic run(input int n, input int pct);
    repeat (n) begin
      @(posedge clk);
      #1;
      instr_ready = ($urandom_range(99) < pct);
    end
  endtask

  initial begin
    logic [5:0] held;
    total       = 0;
    bad         = 0;
    delivered   = 0;
    hold0       = 0;
    hold_prev   = 1'b0;
    reset       = 1'b1;
    instr_ready = 1'b0;
    pc_rule_on  = 1'b0;
    clear_mem();

    // Sequential fetch over the 63 -> 0 wrap, with the hold rule checked each cycle.
    enter_reset();
    clear_mem();
    start_stream(1'b1);
    pc_rule_on = 1'b1;
    run(220, 100);
    pc_rule_on = 1'b0;
    chk("hold_at_zero_seen", 32'(hold0 > 0), 32'd1);
    chk("seq_progress", 32'(delivered >= 120), 32'd1);

    // Backpressure, resume, then reset with a full buffer.
    enter_reset();
    clear_mem();
    start_stream(1'b1);
    pc_rule_on = 1'b1;
    run(3, 100);
    run(10, 0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_no_issue", 32'(imem_en), 32'd0);
    held = pc;
    @(posedge clk);
    #1;
    chk("bp_pc_held", 32'(pc), 32'(held));
    run(40, 100);
    run(8, 0);
    chk("pre_reset_full", 32'(instr_valid), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    chk("midrst_imem_en", 32'(imem_en), 32'd0);
    chk("midrst_pc_address", 32'(pc_address), 32'h3F);
    chk("bp_progress", 32'(delivered >= 20), 32'd1);

    // Forward JAL: +16 bytes at address 3.
    enter_reset();
    clear_mem();
    set_jal(3, 16);
    start_stream(1'b1);
    run(60, 100);
    chk("fwd_progress", 32'(delivered >= 10), 32'd1);

    // JAL to self at address 5.
    enter_reset();
    clear_mem();
    set_jal(5, 0);
    start_stream(1'b1);
    run(60, 100);
    chk("self_progress", 32'(delivered >= 10), 32'd1);

    // Backward JAL: -8 bytes at address 2.
    enter_reset();
    clear_mem();
    set_jal(2, -8);
    start_stream(1'b1);
    run(60, 100);
    chk("back_progress", 32'(delivered >= 10), 32'd1);

    // Random programs with random backpressure.
    for (int r = 0; r < 4; r++) begin
      enter_reset();
      random_mem();
      start_stream(1'b1);
      run(300, 70);
      chk("rand_progress", 32'(delivered >= 30), 32'd1);
    end

    enter_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
